l1_writeback_bus_master: RTL
============================

Name: l1_writeback_bus_master

Overview:
Transmit side of the L1→L2 writeback (flush) bus in the multicore cache subsystem.
- Accepts evicted/dirty words from the two per-core L1 caches through valid/ready handshakes.
- Arbitrates between the cores round-robin and buffers accepted words in a write-merging FIFO.
- Drives one flush pulse per word onto the L2 bus, with address, tag and data held stable for the L2's negedge sampling.

Parameters:
FIFO_DEPTH, 4, number of buffered writeback entries; power of two, >=2
CNT_W, 16, width of the issued-writeback counter

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
wb0_valid  input  1  core 0 has a writeback word
wb0_address  input  32  core 0 word address; bits [1:0] ignored
wb0_data  input  32  core 0 writeback data
wb0_ready  output  1  core 0 word accepted this cycle (combinational)
wb1_valid  input  1  core 1 has a writeback word
wb1_address  input  32  core 1 word address
wb1_data  input  32  core 1 writeback data
wb1_ready  output  1  core 1 word accepted this cycle (combinational)
l2_stall  input  1  L2 busy with a load-miss fetch; no new flush may start
flush  output  1  registered; high = one writeback word presented to L2
bus_address_out  output  32  registered address of presented word, [1:0]=0
bus_tag_out  output  24  registered {address[31:9], source core id}
bus_data_out  output  32  registered data of presented word
fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy
idle  output  1  fifo_count==0 && flush==0
wb_issued  output  CNT_W  wrapping count of flush pulses issued

Behaviour:
Reset (synchronous, active-high):
- flush, bus_address_out, bus_tag_out, bus_data_out, wb_issued = 0.
- FIFO emptied (fifo_count = 0); round-robin pointer rr = 0 (core 0 favoured first).
- Asserting reset mid-operation discards all buffered entries. The next cycle after reset deasserts shows flush = 0.

Arbitration / accept (one accept per cycle max):
- full = (fifo_count == FIFO_DEPTH). No pop-bypass: a full FIFO never accepts, even when popping the same cycle.
- Only wb0 valid: wb0_ready = !full.
- Only wb1 valid: wb1_ready = !full.
- Both valid: only core rr is granted (ready = !full); the other core's ready = 0.
- rr toggles to the other core after every grant to core rr. A grant to the non-favoured core (other core idle) leaves rr unchanged.
- Handshake completes when valid && ready at posedge. The source must hold address/data stable while valid && !ready.

Write merge:
- Compare the accepted word's address[31:2] against every valid entry except the head being popped this same cycle.
- On a match, that entry's data and core id are overwritten in place. No new entry is created and fifo_count is unchanged by the push.
- On no match, the word is appended at the tail.
- Buffer order is preserved.

Issue FSM, two states:
- IDLE: flush = 0. Move to SEND at a posedge where fifo_count > 0 && !l2_stall. At that edge: pop the head into the bus_* registers, set flush <= 1, increment wb_issued.
- SEND: flush = 1 for exactly the cycle following the pop.
  - At the next posedge, if fifo_count > 0 && !l2_stall: pop the next entry, keep flush = 1 (back-to-back), increment wb_issued.
  - Otherwise: flush <= 0, bus_* registers hold their value, go to IDLE.
- A pulse already issued is never withdrawn by l2_stall. Stall only blocks the next pop.
- Latency: a word accepted at edge E into an empty FIFO with no stall → flush high during the cycle after edge E+1.
- Push and pop in the same cycle: fifo_count unchanged (a merge plus a pop gives -1).
- Pointers wrap modulo FIFO_DEPTH. wb_issued wraps at 2^CNT_W.

Test Plan:
- Reset, then wb0 pushes addr 0x0000_1204, data 0xDEAD_BEEF → flush high exactly one cycle. bus_tag_out = {0x000009, 1'b0}, bus_data_out = 0xDEAD_BEEF, wb_issued = 1, idle returns to 1.
- wb0 and wb1 both valid for 4 cycles with distinct addresses, l2_stall = 1 → accepts alternate core0, core1, core0, core1. Then fifo_count = 4 and both readies are 0. Release stall → 4 consecutive flush cycles in accept order.
- Push 0x100/0x11 then 0x100/0x22 while l2_stall = 1 → fifo_count = 1. After release, a single flush with data 0x22.
- l2_stall rises during a SEND cycle with 2 entries queued → the current pulse completes and flush drops next cycle. fifo_count stays 2 until stall falls, then the remaining pulses follow back-to-back.
- FIFO full, a pop occurs and wb1_valid = 1 the same cycle → wb1_ready = 0 that cycle and = 1 the next cycle.
- Assert reset with 3 entries queued and flush = 1 → next cycle flush = 0, fifo_count = 0, wb_issued = 0, idle = 1, and no further pulses.

Source files
------------

// File: rtl/l1_writeback_bus_master_if.sv
// Writeback bus bundle: two per-core L1 writeback request channels on the
// accept side and the registered flush pulse presented to the L2.
interface l1_writeback_bus_master_if;
    logic        wb0_valid;
    logic [31:0] wb0_address;
    logic [31:0] wb0_data;
    logic        wb0_ready;
    logic        wb1_valid;
    logic [31:0] wb1_address;
    logic [31:0] wb1_data;
    logic        wb1_ready;
    logic        l2_stall;
    logic        flush;
    logic [31:0] bus_address_out;
    logic [23:0] bus_tag_out;
    logic [31:0] bus_data_out;

    modport master (
        input  wb0_valid, wb0_address, wb0_data,
        output wb0_ready,
        input  wb1_valid, wb1_address, wb1_data,
        output wb1_ready,
        input  l2_stall,
        output flush, bus_address_out, bus_tag_out, bus_data_out
    );

    modport slave (
        output wb0_valid, wb0_address, wb0_data,
        input  wb0_ready,
        output wb1_valid, wb1_address, wb1_data,
        input  wb1_ready,
        output l2_stall,
        input  flush, bus_address_out, bus_tag_out, bus_data_out
    );
endinterface

// File: rtl/l1_writeback_bus_master.sv
// L1->L2 writeback bus master: round-robin accept from two cores, a
// write-merging FIFO, and a two-state issue FSM that emits one flush pulse
// per buffered word.
module l1_writeback_bus_master #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    l1_writeback_bus_master_if.master     bus,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          idle,
    output logic [CNT_W-1:0]              wb_issued
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CW    = PTR_W + 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t state, state_next;

    logic [29:0]      entry_addr [FIFO_DEPTH];
    logic [31:0]      entry_data [FIFO_DEPTH];
    logic             entry_core [FIFO_DEPTH];
    logic [PTR_W-1:0] head, tail;
    logic [CW-1:0]    count, count_next;
    logic             rr;

    logic             full, grant0, grant1, accept, pop, push_new;
    logic             in_core;
    logic [29:0]      in_addr;
    logic [31:0]      in_data;
    logic             merge_hit;
    logic [PTR_W-1:0] merge_idx;
    logic             unused_low_bits;

    // Word-address bits [1:0] carry no information on this bus.
    assign unused_low_bits = ^{bus.wb0_address[1:0], bus.wb1_address[1:0]};

    assign full     = (count == CW'(FIFO_DEPTH));
    assign pop      = (count != '0) && !bus.l2_stall;

    // Pick the single core allowed to hand over a word this cycle.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (bus.wb0_valid && bus.wb1_valid) begin
            if (rr) grant1 = 1'b1;
            else    grant0 = 1'b1;
        end else begin
            grant0 = bus.wb0_valid;
            grant1 = bus.wb1_valid;
        end
    end

    assign bus.wb0_ready = grant0 && !full;
    assign bus.wb1_ready = grant1 && !full;
    assign accept        = bus.wb0_ready || bus.wb1_ready;
    assign in_core       = bus.wb1_ready;
    assign in_addr       = bus.wb1_ready ? bus.wb1_address[31:2] : bus.wb0_address[31:2];
    assign in_data       = bus.wb1_ready ? bus.wb1_data : bus.wb0_data;

    // Search buffered entries (skipping a head leaving this cycle) for the same word.
    always_comb begin
        merge_hit = 1'b0;
        merge_idx = '0;
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            if (!merge_hit && (CW'(k) < count) && !(pop && (k == 0))
                && (entry_addr[head + PTR_W'(k)] == in_addr)) begin
                merge_hit = 1'b1;
                merge_idx = head + PTR_W'(k);
            end
        end
    end

    assign push_new   = accept && !merge_hit;
    assign count_next = count + CW'(push_new) - CW'(pop);

    // FIFO storage, pointers, occupancy and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            rr    <= 1'b0;
        end else begin
            if (accept && merge_hit) begin
                entry_data[merge_idx] <= in_data;
                entry_core[merge_idx] <= in_core;
            end else if (accept) begin
                entry_addr[tail] <= in_addr;
                entry_data[tail] <= in_data;
                entry_core[tail] <= in_core;
                tail             <= tail + 1'b1;
            end
            if (pop) head <= head + 1'b1;
            count <= count_next;
            if (accept && (in_core == rr)) rr <= ~rr;
        end
    end

    // Bus output registers and issue counter load on every pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.bus_address_out <= '0;
            bus.bus_tag_out     <= '0;
            bus.bus_data_out    <= '0;
            wb_issued           <= '0;
        end else if (pop) begin
            bus.bus_address_out <= {entry_addr[head], 2'b00};
            bus.bus_tag_out     <= {entry_addr[head][29:7], entry_core[head]};
            bus.bus_data_out    <= entry_data[head];
            wb_issued           <= wb_issued + 1'b1;
        end
    end

    // Issue FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Issue FSM next state and flush pulse; a pop always lands in SEND.
    always_comb begin
        state_next = state;
        bus.flush  = 1'b0;
        case (state)
            IDLE: begin
                if (pop) state_next = SEND;
            end
            SEND: begin
                bus.flush  = 1'b1;
                state_next = pop ? SEND : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign fifo_count = count;
    assign idle       = (count == '0) && (state == IDLE);
endmodule
